fifo_uart_tx: RTL and testbench

Serial transmitter that drains the read port of the team's asynchronous FIFO and sends each byte as an asynchronous 8-bit serial frame: start bit, data LSB first, optional even parity, stop bit. It sits entirely in the FIFO read-clock domain and is the consumer end of the FIFO's `rd_en`/`empty`/`data_out` interface. It owns all reads from that FIFO.

---
 rtl/fifo_uart_pkg.sv | 19 +
 rtl/fifo_uart_tx_baud_cnt.sv | 29 ++
 rtl/fifo_uart_tx.sv | 119 +++++++++++
 tb/tb_fifo_uart_tx.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_uart_pkg.sv
// Shared definitions for the FIFO-draining UART transmitter: state encodings,
// frame constants and serial line levels.
package fifo_uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ    = 3'd1,
    LOAD   = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
    PARITY = 3'd5,
    STOP   = 3'd6
  } state_t;

  localparam int   DATA_BITS = 8;
  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_LVL = 1'b0;

endpackage

// File: rtl/fifo_uart_tx_baud_cnt.sv
// Bit-period counter: counts clock cycles within one serial bit and flags the
// last cycle of the bit. Restarts on clear or after each completed bit.
module baud_cnt #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

  logic [W-1:0] count_reg;

  assign tick = (count_reg == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (clear || tick) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + W'(1);
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// Serial transmitter draining an async FIFO read port: start bit, 8 data bits
// LSB first, optional even parity, stop bit. tx is registered (glitch free).
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_rd_en,
  output logic       tx,
  output logic       busy
);

  state_t state_reg, state_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic [2:0] bit_reg, bit_next;
  logic parity_reg, parity_next;
  logic tx_reg, tx_next;
  logic tick;
  logic clear;

  baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .rst  (rst),
    .clear(clear),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      shift_reg  <= '0;
      bit_reg    <= '0;
      parity_reg <= 1'b0;
      tx_reg     <= LINE_IDLE;
    end else begin
      state_reg  <= state_next;
      shift_reg  <= shift_next;
      bit_reg    <= bit_next;
      parity_reg <= parity_next;
      tx_reg     <= tx_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    shift_next  = shift_reg;
    bit_next    = bit_reg;
    parity_next = parity_reg;
    fifo_rd_en  = 1'b0;

    case (state_reg)
      IDLE: begin
        if (enable && !fifo_empty) begin
          state_next = REQ;
        end
      end
      REQ: begin
        // A late-rising empty here would be a second consumer; back off without reading.
        fifo_rd_en = !fifo_empty;
        state_next = fifo_empty ? IDLE : LOAD;
      end
      LOAD: begin
        shift_next  = fifo_data;
        parity_next = ^fifo_data;
        bit_next    = '0;
        state_next  = START;
      end
      START: begin
        if (tick) begin
          state_next = DATA;
        end
      end
      DATA: begin
        if (tick) begin
          shift_next = shift_reg >> 1;
          bit_next   = bit_reg + 3'd1;
          if (bit_reg == 3'(DATA_BITS - 1)) begin
            state_next = (PARITY_EN != 0) ? PARITY : STOP;
          end
        end
      end
      PARITY: begin
        if (tick) begin
          state_next = STOP;
        end
      end
      STOP: begin
        if (tick) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    clear = (state_next != state_reg);

    // Line level is chosen from the upcoming state so it lands in tx_reg on entry.
    case (state_next)
      START:   tx_next = START_LVL;
      DATA:    tx_next = shift_next[0];
      PARITY:  tx_next = parity_next;
      default: tx_next = LINE_IDLE;
    endcase
  end

  assign tx   = tx_reg;
  assign busy = (state_reg != IDLE);

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: lane 0 without parity, lane 1 with even parity, each
// fed by its own FIFO model; a timeline model predicts tx/busy/rd_en each cycle.
module tb_fifo_uart_tx;

  localparam int CPB = 4;
  localparam int NL  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;
  logic [NL-1:0] fifo_empty;
  logic [NL-1:0] fifo_rd_en;
  logic [NL-1:0] tx;
  logic [NL-1:0] busy;
  logic [7:0] fifo_data [NL];

  logic [7:0] mem [256];
  int wptr = 0;
  int wr_seen = 0;
  int pipe0 = 0;
  int pipe1 = 0;
  int rptr    [NL] = '{default: 0};
  int vis_cnt [NL] = '{default: 0};
  int rd_cnt  [NL] = '{default: 0};

  int cyc = 0;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NL; gi++) begin : g_lane
    fifo_uart_tx #(
      .CLKS_PER_BIT(CPB),
      .PARITY_EN   (gi)
    ) dut (
      .clk       (clk),
      .rst       (rst),
      .enable    (enable),
      .fifo_empty(fifo_empty[gi]),
      .fifo_data (fifo_data[gi]),
      .fifo_rd_en(fifo_rd_en[gi]),
      .tx        (tx[gi]),
      .busy      (busy[gi])
    );
    assign fifo_empty[gi] = (vis_cnt[gi] == 0);
  end

  task automatic check_bit(input string name, input int l, input logic got, input logic want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s lane=%0d cyc=%0d got=%b want=%b", name, l, cyc, got, want);
    end
  endtask

  task automatic check_int(input string name, input int l, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s lane=%0d cyc=%0d got=%0d want=%0d", name, l, cyc, got, want);
    end
  endtask

  function automatic int flen(input int l);
    return (10 + l) * CPB;
  endfunction

  // Level of frame bit k: start, data LSB first, optional even parity, then stop.
  function automatic logic frame_bit(input logic [7:0] b, input int par, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (k == 9 && par != 0) return ^b;
    return 1'b1;
  endfunction

  function automatic logic [10:0] exp_frame(input int l, input logic [7:0] b);
    if (l != 0) return {1'b1, ^b, b, 1'b0};
    return {2'b01, b, 1'b0};
  endfunction

  // FIFO model: registered data_out, writes become visible after a synchronizer delay.
  always @(posedge clk) begin
    for (int l = 0; l < NL; l++) begin
      if (fifo_rd_en[l] && vis_cnt[l] != 0) begin
        fifo_data[l] <= mem[rptr[l]];
        rptr[l]      <= rptr[l] + 1;
        rd_cnt[l]    <= rd_cnt[l] + 1;
        vis_cnt[l]   <= vis_cnt[l] - 1 + pipe1;
      end else begin
        vis_cnt[l]   <= vis_cnt[l] + pipe1;
      end
    end
    pipe1   <= pipe0;
    pipe0   <= wptr - wr_seen;
    wr_seen <= wptr;
  end

  // Reference timeline: a frame is decided in an idle cycle, then REQ, LOAD and the bits follow.
  bit         act  [NL];
  int         dcyc [NL];
  logic [7:0] byt  [NL];

  always @(negedge clk) begin
    bit   a;
    int   o;
    logic e_tx, e_busy, e_rd;
    cyc <= cyc + 1;
    for (int l = 0; l < NL; l++) begin
      a = act[l];
      o = cyc - dcyc[l];
      if (rst) a = 1'b0;
      else if (a && o > 2 + flen(l)) a = 1'b0;
      e_tx = 1'b1;
      e_busy = 1'b0;
      e_rd = 1'b0;
      if (a) begin
        e_busy = 1'b1;
        e_rd   = (o == 1);
        e_tx   = (o < 3) ? 1'b1 : frame_bit(byt[l], l, (o - 3) / CPB);
      end else if (!rst && enable && !fifo_empty[l]) begin
        a = 1'b1;
        dcyc[l] <= cyc;
        byt[l]  <= mem[rptr[l]];
      end
      act[l] <= a;
      check_bit("tx", l, tx[l], e_tx);
      check_bit("busy", l, busy[l], e_busy);
      check_bit("rd_en", l, fifo_rd_en[l], e_rd);
      check_bit("no_underflow", l, fifo_rd_en[l] & fifo_empty[l], 1'b0);
    end
  end

  // Serial receiver: samples the middle of each bit after a falling edge.
  bit          inf     [NL];
  int          mcnt    [NL];
  int          sstart  [NL];
  logic        prev_tx [NL];
  logic [10:0] fbits   [NL];
  logic [10:0] rx_frame [NL][64];
  int          rx_start [NL][64];
  int          rx_n    [NL] = '{default: 0};

  always @(negedge clk) begin
    logic [10:0] fb;
    for (int l = 0; l < NL; l++) begin
      if (rst) begin
        inf[l]     <= 1'b0;
        prev_tx[l] <= 1'b1;
      end else begin
        prev_tx[l] <= tx[l];
        if (!inf[l]) begin
          if (prev_tx[l] === 1'b1 && tx[l] === 1'b0) begin
            inf[l]    <= 1'b1;
            mcnt[l]   <= 1;
            fbits[l]  <= '0;
            sstart[l] <= cyc;
          end
        end else begin
          fb = fbits[l];
          if (mcnt[l] % CPB == CPB / 2) fb[mcnt[l] / CPB] = tx[l];
          fbits[l] <= fb;
          mcnt[l]  <= mcnt[l] + 1;
          if (mcnt[l] == (9 + l) * CPB + CPB / 2) begin
            rx_frame[l][rx_n[l]] <= fb;
            rx_start[l][rx_n[l]] <= sstart[l];
            rx_n[l] <= rx_n[l] + 1;
            inf[l]  <= 1'b0;
          end
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [7:0] b);
    mem[wptr] = b;
    wptr = wptr + 1;
  endtask

  task automatic wait_quiet(input int budget);
    bit quiet;
    quiet = 1'b0;
    for (int i = 0; i < budget && !quiet; i++) begin
      quiet = (busy == '0) && (vis_cnt[0] == 0) && (vis_cnt[1] == 0) &&
              (pipe0 == 0) && (pipe1 == 0) && (wptr == wr_seen);
      if (!quiet) step(1);
    end
    check_bit("quiet_within_budget", 0, quiet, 1'b1);
    step(3);
  endtask

  task automatic wait_busy(input int budget);
    for (int i = 0; i < budget && !busy[0]; i++) step(1);
    check_bit("busy_rise", 0, busy[0], 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, b1, r0, r1, n0, n1, wbase;
    int rxb [NL];
    logic [7:0] v;

    // Reset state.
    step(3);
    for (int l = 0; l < NL; l++) begin
      check_bit("rst_tx", l, tx[l], 1'b1);
      check_bit("rst_busy", l, busy[l], 1'b0);
      check_bit("rst_rd_en", l, fifo_rd_en[l], 1'b0);
    end
    rst = 1'b0;
    enable = 1'b1;
    step(2);

    // Single byte 0xA5.
    b0 = rx_n[0]; b1 = rx_n[1]; r0 = rd_cnt[0];
    push(8'hA5);
    wait_busy(50);
    n0 = 0; n1 = 0;
    for (int i = 0; i < 200 && (busy != '0); i++) begin
      if (busy[0]) n0++;
      if (busy[1]) n1++;
      step(1);
    end
    wait_quiet(300);
    check_int("a5_busy_len", 0, n0, 42);
    check_int("a5_busy_len", 1, n1, 46);
    check_int("a5_rd_pulses", 0, rd_cnt[0] - r0, 1);
    check_int("a5_frame", 0, int'(rx_frame[0][b0][9:0]), int'(10'b1101001010));
    check_int("a5_frame", 1, int'(rx_frame[1][b1]), int'({2'b10, 8'hA5, 1'b0}));
    $display("txn single 0xA5 lane0=%03h lane1=%03h", rx_frame[0][b0], rx_frame[1][b1]);

    // Parity: 0x07 then 0x03, back to back.
    b0 = rx_n[0]; b1 = rx_n[1];
    push(8'h07);
    push(8'h03);
    wait_quiet(400);
    check_int("par07_frame", 1, int'(rx_frame[1][b1]), int'({2'b11, 8'h07, 1'b0}));
    check_int("par03_frame", 1, int'(rx_frame[1][b1+1]), int'({2'b10, 8'h03, 1'b0}));
    check_int("par_period", 1, rx_start[1][b1+1] - rx_start[1][b1], 47);
    check_int("nopar_period", 0, rx_start[0][b0+1] - rx_start[0][b0], 43);
    $display("txn parity 0x07 0x03 lane1=%03h %03h", rx_frame[1][b1], rx_frame[1][b1+1]);

    // Back-to-back 0x01 0x02 0x03.
    b0 = rx_n[0]; r0 = rd_cnt[0];
    push(8'h01);
    push(8'h02);
    push(8'h03);
    wait_quiet(500);
    check_int("b2b_rd_pulses", 0, rd_cnt[0] - r0, 3);
    check_int("b2b_space01", 0, rx_start[0][b0+1] - rx_start[0][b0], 43);
    check_int("b2b_space12", 0, rx_start[0][b0+2] - rx_start[0][b0+1], 43);
    for (int k = 0; k < 3; k++) begin
      v = 8'(k + 1);
      check_int("b2b_data", 0, int'(rx_frame[0][b0+k][8:1]), int'(v));
      $display("txn b2b byte%0d lane0 data=%02h", k, rx_frame[0][b0+k][8:1]);
    end

    // Enable gating: drop enable 10 cycles into the first frame.
    b0 = rx_n[0]; r0 = rd_cnt[0]; r1 = rd_cnt[1];
    push(8'h5A);
    push(8'hC3);
    wait_busy(50);
    step(10);
    enable = 1'b0;
    step(150);
    check_int("gate_rd_pulses", 0, rd_cnt[0] - r0, 1);
    check_int("gate_rd_pulses", 1, rd_cnt[1] - r1, 1);
    check_int("gate_pending", 0, vis_cnt[0], 1);
    check_int("gate_first", 0, int'(rx_frame[0][b0][8:1]), 32'h5A);
    enable = 1'b1;
    wait_quiet(300);
    check_int("gate_resume", 0, int'(rx_frame[0][b0+1][8:1]), 32'hC3);
    $display("txn gating lane0 %02h then %02h", rx_frame[0][b0][8:1], rx_frame[0][b0+1][8:1]);

    // Reset during DATA bit 3: 0x96 is lost, 0x3C follows cleanly.
    b0 = rx_n[0]; b1 = rx_n[1];
    push(8'h96);
    push(8'h3C);
    wait_busy(50);
    step(19);
    rst = 1'b1;
    #1;
    for (int l = 0; l < NL; l++) begin
      check_bit("async_rst_tx", l, tx[l], 1'b1);
      check_bit("async_rst_busy", l, busy[l], 1'b0);
      check_bit("async_rst_rd_en", l, fifo_rd_en[l], 1'b0);
    end
    step(2);
    rst = 1'b0;
    wait_quiet(300);
    check_int("rst_frames", 0, rx_n[0] - b0, 1);
    check_int("rst_next", 0, int'(rx_frame[0][b0]), int'(exp_frame(0, 8'h3C)));
    check_int("rst_next", 1, int'(rx_frame[1][b1]), int'(exp_frame(1, 8'h3C)));
    $display("txn reset lane0 next=%02h", rx_frame[0][b0][8:1]);

    // Random traffic with random enable pauses.
    wbase = wptr;
    for (int l = 0; l < NL; l++) rxb[l] = rx_n[l];
    for (int k = 0; k < 20; k++) begin
      push(8'($urandom_range(0, 255)));
      if ($urandom_range(0, 4) == 0) begin
        enable = 1'b0;
        step($urandom_range(1, 50));
        enable = 1'b1;
      end
      step($urandom_range(0, 60));
    end
    enable = 1'b1;
    wait_quiet(5000);
    for (int l = 0; l < NL; l++) begin
      check_int("rand_count", l, rx_n[l] - rxb[l], 20);
      for (int k = 0; k < 20; k++) begin
        check_int("rand_frame", l, int'(rx_frame[l][rxb[l]+k]), int'(exp_frame(l, mem[wbase+k])));
        $display("txn rand lane%0d #%0d wrote=%02h got=%03h", l, k, mem[wbase+k], rx_frame[l][rxb[l]+k]);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
